mmu_table_walker: RTL and testbench
===================================

Name: mmu_table_walker

Overview:
Hardware page-table walker that sits directly upstream of the MMU TLB. On a TLB miss it fetches page-table entries from memory and refills the TLB through its write port. Level-1 mode does one fetch. Level-2 mode does two fetches: a directory entry, then an entry pair. Every TLB refill writes a 2-line pair of 32-bit entries, one 64-bit memory beat.

Parameters:
None. All sizes come from the shared MMU package.

Ports:
iCLOCK  in  1  clock
iRESET  in  1  asynchronous, active-high reset
iREMOVE  in  1  flush; aborts any walk in progress
iREQ  in  1  walk request (TLB miss), sampled only in IDLE
iMOD  in  2  paging mode (package constants)
iPS  in  3  page-size code
iVADDR  in  32  missing virtual address
iBASE  in  32  page directory/table base; bits [11:0] ignored
oBUSY  out  1  high whenever state != IDLE
oMEM_REQ  out  1  64-bit read request
oMEM_ADDR  out  32  read address, 8-byte aligned
iMEM_LOCK  in  1  memory busy; request is not accepted while high
iMEM_VALID  in  1  read data valid (one beat per request)
iMEM_DATA  in  64  [31:0] = even entry, [63:32] = odd entry
oTLB_WR_REQ  out  1  TLB refill strobe, one cycle
oTLB_WR_MOD  out  2  latched iMOD
oTLB_WR_PS  out  3  latched iPS
oTLB_WR_ADDR  out  32  latched iVADDR
oTLB_WR_PHYS_ADDR  out  64  fetched entry pair
oDONE  out  1  walk-complete pulse, one cycle
oFAULT  out  2  fault code, valid with oDONE: 0 none, 1 directory not present, 2 page not present, 3 bad mode

Behaviour:
- Reset (iRESET high, asynchronous):
  - state = IDLE.
  - All outputs 0: oBUSY, oMEM_REQ, oMEM_ADDR, oTLB_WR_*, oDONE, oFAULT.
- Shift S = log2(page size):
  - Level 1: PS 0..4 gives S = 17..21.
  - Level 2: PS 0..4 gives S = 12..16.
  - PS codes above 4 are treated as bad mode.
- Address arithmetic is 32-bit and wraps modulo 2^32.
- Level-1 entry-pair address = {iBASE[31:12],12'h0} + ((iVADDR >> (S+1)) << 3).
- Level-2 directory:
  - Directory entry address = {iBASE[31:12],12'h0} + (iVADDR[31:22] << 2).
  - The issued read is that address with bits [2:0] = 0.
  - The entry is taken from iMEM_DATA[63:32] when dir index bit 0 = 1, else from [31:0].
  - Entry bit 0 = present; entry [31:12] = table base.
- Level-2 entry-pair address = {tbase,12'h0} + ((iVADDR[21:0] >> (S+1)) << 3).
- Line select = iVADDR[S]. A fault is raised only if the selected entry's bit 0 = 0; the other entry of the pair is not checked.
- States:
  - IDLE: if iREQ, latch iMOD/iPS/iVADDR/iBASE.
    - Bad mode (iMOD not L1/L2, or PS > 4): go to DONE with fault 3.
    - Level 1: go to PAIR_REQ.
    - Level 2: go to DIR_REQ.
  - DIR_REQ / PAIR_REQ: oMEM_REQ = 1 with a stable address. The request is accepted on the first edge with iMEM_LOCK = 0; then go to DIR_WAIT / PAIR_WAIT.
  - DIR_WAIT: on iMEM_VALID, if not present go to DONE with fault 1; else latch tbase and go to PAIR_REQ.
  - PAIR_WAIT: on iMEM_VALID, latch data. If not present, go to DONE with fault 2; else go to WRITE.
  - WRITE: oTLB_WR_REQ = 1 and oDONE = 1 for one cycle, oFAULT = 0; then IDLE.
  - DONE (fault): oDONE = 1 for one cycle with the code, no TLB write; then IDLE.
  - DRAIN: wait for iMEM_VALID, discard the data, then IDLE. oBUSY stays high.
- Latency:
  - iREQ sampled at edge N gives oMEM_REQ from cycle N+1.
  - The last iMEM_VALID at edge M gives oTLB_WR_REQ/oDONE during cycle M+1.
  - Level 1 with zero memory wait: 3 cycles from request to write.
- Only one memory request is ever outstanding. oMEM_REQ drops the cycle after acceptance.
- iREMOVE:
  - In *_REQ: go to IDLE with no pulses.
  - In *_WAIT: go to DRAIN.
  - In WRITE/DONE: the pulse is suppressed, go to IDLE.
  - In IDLE: iREQ in the same cycle is ignored.
- iREQ while busy is ignored; the requester must hold it until oBUSY falls.
- iMEM_VALID outside WAIT/DRAIN is ignored.

Decomposition:
Shared package mmu_pkg holds:
- paging mode constants (L1 = 2'h1, L2 = 2'h2);
- page-size codes 0..4;
- fault codes;
- state enum;
- a function ps_to_shift(mod, ps) returning 5-bit S, plus a bad flag.

One sub-module, mmu_walk_addr_gen: combinational directory/pair address and line-select generation from mod, ps, vaddr, base and tbase.

Test Plan:
- L2, PS 0 (4K), iBASE 0x0010_0000, iVADDR 0x0040_3000:
  - Read at 0x0010_0000; return [63:32] = 0x0020_0001.
  - Read at 0x0020_0008; return 0x00AB_C003_0012_3003.
  - Expect oTLB_WR_REQ with PHYS 0x00ABC003_00123003, ADDR 0x0040_3000, oFAULT 0.
- L1, PS 0 (128K), iBASE 0x0100_0000, iVADDR 0x0006_0000:
  - Read at 0x0100_0008; return odd entry 0x0000_0000.
  - Expect oDONE, oFAULT = 2, no oTLB_WR_REQ.
- L2 directory entry 0x0020_0000 (not present): expect oFAULT = 1 after one read only.
- iMOD = 0: expect oDONE with oFAULT = 3 at cycle N+1 and no oMEM_REQ.
- iMEM_LOCK held 5 cycles: oMEM_REQ and oMEM_ADDR stay stable; exactly one acceptance.
- iREMOVE in PAIR_WAIT:
  - Expect DRAIN with oBUSY held; the late iMEM_VALID is discarded, with no write and no oDONE.
  - Then IDLE; iRESET mid-walk zeroes all outputs asynchronously.

Source files
------------

// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - shared MMU constants, walker state enum and page-size shift helper
package mmu_pkg;

  localparam logic [1:0] MMU_MODE_L1 = 2'h1;
  localparam logic [1:0] MMU_MODE_L2 = 2'h2;

  localparam logic [2:0] MMU_PS_0   = 3'd0;
  localparam logic [2:0] MMU_PS_1   = 3'd1;
  localparam logic [2:0] MMU_PS_2   = 3'd2;
  localparam logic [2:0] MMU_PS_3   = 3'd3;
  localparam logic [2:0] MMU_PS_4   = 3'd4;
  localparam logic [2:0] MMU_PS_MAX = MMU_PS_4;

  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_DIR_NP   = 2'd1;
  localparam logic [1:0] FAULT_PAGE_NP  = 2'd2;
  localparam logic [1:0] FAULT_BAD_MODE = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIR_REQ,
    ST_DIR_WAIT,
    ST_PAIR_REQ,
    ST_PAIR_WAIT,
    ST_WRITE,
    ST_DONE,
    ST_DRAIN
  } walk_state_t;

  typedef struct packed {
    logic       bad;
    logic [4:0] shift;
  } walk_shift_t;

  // Level-1 pages are 32x larger than level-2 pages for the same code.
  function automatic walk_shift_t ps_to_shift(input logic [1:0] mod, input logic [2:0] ps);
    walk_shift_t res;
    res.bad   = 1'b0;
    res.shift = 5'd0;
    if (ps > MMU_PS_MAX) begin
      res.bad = 1'b1;
    end else if (mod == MMU_MODE_L1) begin
      res.shift = 5'd17 + {2'b00, ps};
    end else if (mod == MMU_MODE_L2) begin
      res.shift = 5'd12 + {2'b00, ps};
    end else begin
      res.bad = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mmu_walk_addr_gen.sv
// rtl/mmu_walk_addr_gen.sv - combinational directory/pair address and line-select generation
module mmu_walk_addr_gen
  import mmu_pkg::*;
(
  input  logic [1:0]  i_mod,
  input  logic [2:0]  i_ps,
  input  logic [31:0] i_vaddr,
  input  logic [19:0] i_base,
  input  logic [19:0] i_tbase,
  output logic [31:0] o_dir_addr,
  output logic        o_dir_odd,
  output logic [31:0] o_pair_addr,
  output logic        o_line_sel
);

  walk_shift_t w_sh;
  logic [4:0]  w_shift_p1;
  logic [31:0] w_l1_off;
  logic [31:0] w_l2_off;
  logic        w_unused_bad;

  assign w_sh         = ps_to_shift(i_mod, i_ps);
  assign w_unused_bad = w_sh.bad;
  assign w_shift_p1   = w_sh.shift + 5'd1;

  // Base is 4K aligned, so dropping index bit 0 gives the 8-byte aligned beat directly.
  assign o_dir_addr = {i_base, 12'h000} + {20'h00000, i_vaddr[31:23], 3'b000};
  assign o_dir_odd  = i_vaddr[22];

  assign w_l1_off = (i_vaddr >> w_shift_p1) << 3;
  assign w_l2_off = ({10'h000, i_vaddr[21:0]} >> w_shift_p1) << 3;

  assign o_pair_addr = (i_mod == MMU_MODE_L2) ? ({i_tbase, 12'h000} + w_l2_off)
                                              : ({i_base, 12'h000} + w_l1_off);
  assign o_line_sel  = i_vaddr[w_sh.shift];

endmodule

// File: rtl/mmu_table_walker.sv
// rtl/mmu_table_walker.sv - page-table walker refilling the TLB on a miss
module mmu_table_walker
  import mmu_pkg::*;
(
  input  logic        iCLOCK,
  input  logic        iRESET,
  input  logic        iREMOVE,
  input  logic        iREQ,
  input  logic [1:0]  iMOD,
  input  logic [2:0]  iPS,
  input  logic [31:0] iVADDR,
  input  logic [31:0] iBASE,
  output logic        oBUSY,
  output logic        oMEM_REQ,
  output logic [31:0] oMEM_ADDR,
  input  logic        iMEM_LOCK,
  input  logic        iMEM_VALID,
  input  logic [63:0] iMEM_DATA,
  output logic        oTLB_WR_REQ,
  output logic [1:0]  oTLB_WR_MOD,
  output logic [2:0]  oTLB_WR_PS,
  output logic [31:0] oTLB_WR_ADDR,
  output logic [63:0] oTLB_WR_PHYS_ADDR,
  output logic        oDONE,
  output logic [1:0]  oFAULT
);

  walk_state_t r_state;
  walk_state_t w_next;

  logic [1:0]  r_mod;
  logic [2:0]  r_ps;
  logic [31:0] r_vaddr;
  logic [19:0] r_base;
  logic [19:0] r_tbase;
  logic [63:0] r_data;
  logic [1:0]  r_fault;

  walk_shift_t w_req_shift;
  logic        w_unused;
  logic        w_accept;
  logic [31:0] w_dir_addr;
  logic        w_dir_odd;
  logic [31:0] w_pair_addr;
  logic        w_line_sel;
  logic        w_dir_present;
  logic [19:0] w_dir_tbase;
  logic        w_pair_present;

  assign w_req_shift = ps_to_shift(iMOD, iPS);
  assign w_unused    = ^{iBASE[11:0], w_req_shift.shift};
  assign w_accept    = (r_state == ST_IDLE) && iREQ && !iREMOVE;

  mmu_walk_addr_gen u_addr_gen (
    .i_mod       (r_mod),
    .i_ps        (r_ps),
    .i_vaddr     (r_vaddr),
    .i_base      (r_base),
    .i_tbase     (r_tbase),
    .o_dir_addr  (w_dir_addr),
    .o_dir_odd   (w_dir_odd),
    .o_pair_addr (w_pair_addr),
    .o_line_sel  (w_line_sel)
  );

  assign w_dir_present  = w_dir_odd ? iMEM_DATA[32] : iMEM_DATA[0];
  assign w_dir_tbase    = w_dir_odd ? iMEM_DATA[63:44] : iMEM_DATA[31:12];
  assign w_pair_present = w_line_sel ? iMEM_DATA[32] : iMEM_DATA[0];

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A flush that coincides with the returning beat leaves nothing outstanding, so skip DRAIN.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_req_shift.bad)          w_next = ST_DONE;
          else if (iMOD == MMU_MODE_L1) w_next = ST_PAIR_REQ;
          else                          w_next = ST_DIR_REQ;
        end
      end
      ST_DIR_REQ: begin
        if (iREMOVE)         w_next = ST_IDLE;
        else if (!iMEM_LOCK) w_next = ST_DIR_WAIT;
      end
      ST_DIR_WAIT: begin
        if (iREMOVE)         w_next = iMEM_VALID ? ST_IDLE : ST_DRAIN;
        else if (iMEM_VALID) w_next = w_dir_present ? ST_PAIR_REQ : ST_DONE;
      end
      ST_PAIR_REQ: begin
        if (iREMOVE)         w_next = ST_IDLE;
        else if (!iMEM_LOCK) w_next = ST_PAIR_WAIT;
      end
      ST_PAIR_WAIT: begin
        if (iREMOVE)         w_next = iMEM_VALID ? ST_IDLE : ST_DRAIN;
        else if (iMEM_VALID) w_next = w_pair_present ? ST_WRITE : ST_DONE;
      end
      ST_WRITE: w_next = ST_IDLE;
      ST_DONE:  w_next = ST_IDLE;
      ST_DRAIN: begin
        if (iMEM_VALID) w_next = ST_IDLE;
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      r_mod   <= 2'd0;
      r_ps    <= 3'd0;
      r_vaddr <= 32'd0;
      r_base  <= 20'd0;
      r_tbase <= 20'd0;
      r_data  <= 64'd0;
      r_fault <= FAULT_NONE;
    end else begin
      if (w_accept) begin
        r_mod   <= iMOD;
        r_ps    <= iPS;
        r_vaddr <= iVADDR;
        r_base  <= iBASE[31:12];
        r_fault <= w_req_shift.bad ? FAULT_BAD_MODE : FAULT_NONE;
      end
      if ((r_state == ST_DIR_WAIT) && iMEM_VALID && !iREMOVE) begin
        r_tbase <= w_dir_tbase;
        if (!w_dir_present) r_fault <= FAULT_DIR_NP;
      end
      if ((r_state == ST_PAIR_WAIT) && iMEM_VALID && !iREMOVE) begin
        r_data  <= iMEM_DATA;
        r_fault <= w_pair_present ? FAULT_NONE : FAULT_PAGE_NP;
      end
    end
  end

  always_comb begin
    oBUSY       = (r_state != ST_IDLE);
    oMEM_REQ    = 1'b0;
    oMEM_ADDR   = 32'd0;
    oTLB_WR_REQ = 1'b0;
    oDONE       = 1'b0;
    oFAULT      = FAULT_NONE;
    case (r_state)
      ST_DIR_REQ: begin
        oMEM_REQ  = 1'b1;
        oMEM_ADDR = w_dir_addr;
      end
      ST_PAIR_REQ: begin
        oMEM_REQ  = 1'b1;
        oMEM_ADDR = w_pair_addr;
      end
      ST_WRITE: begin
        oTLB_WR_REQ = !iREMOVE;
        oDONE       = !iREMOVE;
      end
      ST_DONE: begin
        oDONE  = !iREMOVE;
        oFAULT = iREMOVE ? FAULT_NONE : r_fault;
      end
      default: ;
    endcase
  end

  assign oTLB_WR_MOD       = r_mod;
  assign oTLB_WR_PS        = r_ps;
  assign oTLB_WR_ADDR      = r_vaddr;
  assign oTLB_WR_PHYS_ADDR = r_data;

endmodule

// File: tb/tb_mmu_table_walker.sv
// tb/tb_mmu_table_walker.sv - directed vector bench for mmu_table_walker
module tb_mmu_table_walker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iREMOVE = 1'b0;
  logic        iREQ = 1'b0;
  logic [1:0]  iMOD = 2'd0;
  logic [2:0]  iPS = 3'd0;
  logic [31:0] iVADDR = 32'd0;
  logic [31:0] iBASE = 32'd0;
  logic        oBUSY;
  logic        oMEM_REQ;
  logic [31:0] oMEM_ADDR;
  logic        iMEM_LOCK = 1'b0;
  logic        iMEM_VALID = 1'b0;
  logic [63:0] iMEM_DATA = 64'd0;
  logic        oTLB_WR_REQ;
  logic [1:0]  oTLB_WR_MOD;
  logic [2:0]  oTLB_WR_PS;
  logic [31:0] oTLB_WR_ADDR;
  logic [63:0] oTLB_WR_PHYS_ADDR;
  logic        oDONE;
  logic [1:0]  oFAULT;

  int n_total = 0;
  int n_pass  = 0;

  mmu_table_walker dut (
    .iCLOCK            (clk),
    .iRESET            (rst),
    .iREMOVE           (iREMOVE),
    .iREQ              (iREQ),
    .iMOD              (iMOD),
    .iPS               (iPS),
    .iVADDR            (iVADDR),
    .iBASE             (iBASE),
    .oBUSY             (oBUSY),
    .oMEM_REQ          (oMEM_REQ),
    .oMEM_ADDR         (oMEM_ADDR),
    .iMEM_LOCK         (iMEM_LOCK),
    .iMEM_VALID        (iMEM_VALID),
    .iMEM_DATA         (iMEM_DATA),
    .oTLB_WR_REQ       (oTLB_WR_REQ),
    .oTLB_WR_MOD       (oTLB_WR_MOD),
    .oTLB_WR_PS        (oTLB_WR_PS),
    .oTLB_WR_ADDR      (oTLB_WR_ADDR),
    .oTLB_WR_PHYS_ADDR (oTLB_WR_PHYS_ADDR),
    .oDONE             (oDONE),
    .oFAULT            (oFAULT)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  typedef struct {
    logic [1:0]  mod;
    logic [2:0]  ps;
    logic [31:0] vaddr;
    logic [31:0] base;
    logic [31:0] a0;
    logic [63:0] d0;
    logic [31:0] a1;
    logic [63:0] d1;
    int          nreads;
    logic [1:0]  fault;
    logic        wr;
    logic [63:0] phys;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int edges;
    int nreads;
    logic got_done;
    logic pulses;

    vecs[0] = '{2'h2, 3'd0, 32'h0040_3000, 32'h0010_0000, 32'h0010_0000, 64'h0020_0001_0000_0000,
                32'h0020_0008, 64'h00AB_C003_0012_3003, 2, 2'd0, 1'b1, 64'h00AB_C003_0012_3003, 5};
    vecs[1] = '{2'h1, 3'd0, 32'h0006_0000, 32'h0100_0000, 32'h0100_0008, 64'h0000_0000_0000_0001,
                32'h0, 64'h0, 1, 2'd2, 1'b0, 64'h0, 3};
    vecs[2] = '{2'h2, 3'd0, 32'h0000_0000, 32'h0010_0000, 32'h0010_0000, 64'h0030_0001_0020_0000,
                32'h0, 64'h0, 1, 2'd1, 1'b0, 64'h0, 3};
    vecs[3] = '{2'h0, 3'd0, 32'h0000_1000, 32'h0010_0000, 32'h0, 64'h0,
                32'h0, 64'h0, 0, 2'd3, 1'b0, 64'h0, 1};
    vecs[4] = '{2'h1, 3'd4, 32'h8060_0000, 32'h0200_0000, 32'h0200_1008, 64'h1234_5001_0000_0000,
                32'h0, 64'h0, 1, 2'd0, 1'b1, 64'h1234_5001_0000_0000, 3};
    vecs[5] = '{2'h2, 3'd2, 32'h00C0_9000, 32'h0030_0000, 32'h0030_0008, 64'h0050_0001_0000_0000,
                32'h0050_0008, 64'h0000_0000_0777_7001, 2, 2'd0, 1'b1, 64'h0000_0000_0777_7001, 5};
    vecs[6] = '{2'h1, 3'd5, 32'h0000_0000, 32'h0010_0000, 32'h0, 64'h0,
                32'h0, 64'h0, 0, 2'd3, 1'b0, 64'h0, 1};
    vecs[7] = '{2'h1, 3'd0, 32'hFFFC_0000, 32'hFFFF_FABC, 32'h0001_EFF8, 64'h0000_0000_ABCD_0001,
                32'h0, 64'h0, 1, 2'd0, 1'b1, 64'h0000_0000_ABCD_0001, 3};

    #2;
    check("rst_ctrl", {60'd0, oBUSY, oMEM_REQ, oDONE, oTLB_WR_REQ}, 64'd0);
    check("rst_addr", {32'd0, oMEM_ADDR}, 64'd0);
    check("rst_tlb", {oTLB_WR_MOD, oTLB_WR_PS, oTLB_WR_ADDR, oFAULT}, 64'd0);
    check("rst_phys", oTLB_WR_PHYS_ADDR, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      iMOD = vecs[v].mod; iPS = vecs[v].ps; iVADDR = vecs[v].vaddr; iBASE = vecs[v].base;
      iREQ = 1'b1;
      step();
      iREQ = 1'b0;
      edges = 1; nreads = 0; got_done = 1'b0;
      while (!got_done && edges < 40) begin
        if (oDONE) begin
          got_done = 1'b1;
        end else if (oMEM_REQ) begin
          if (nreads == 0) check($sformatf("v%0d_addr0", v), {32'd0, oMEM_ADDR}, {32'd0, vecs[v].a0});
          else check($sformatf("v%0d_addr1", v), {32'd0, oMEM_ADDR}, {32'd0, vecs[v].a1});
          step(); edges++;
          iMEM_VALID = 1'b1;
          iMEM_DATA = (nreads == 0) ? vecs[v].d0 : vecs[v].d1;
          step(); edges++;
          iMEM_VALID = 1'b0;
          nreads++;
        end else begin
          step(); edges++;
        end
      end
      check($sformatf("v%0d_done", v), {63'd0, got_done}, 64'd1);
      check($sformatf("v%0d_latency", v), edges, vecs[v].lat);
      check($sformatf("v%0d_reads", v), nreads, vecs[v].nreads);
      check($sformatf("v%0d_fault", v), {62'd0, oFAULT}, {62'd0, vecs[v].fault});
      check($sformatf("v%0d_wr", v), {63'd0, oTLB_WR_REQ}, {63'd0, vecs[v].wr});
      if (vecs[v].wr) begin
        check($sformatf("v%0d_phys", v), oTLB_WR_PHYS_ADDR, vecs[v].phys);
        check($sformatf("v%0d_vaddr", v), {32'd0, oTLB_WR_ADDR}, {32'd0, vecs[v].vaddr});
        check($sformatf("v%0d_modps", v), {59'd0, oTLB_WR_MOD, oTLB_WR_PS}, {59'd0, vecs[v].mod, vecs[v].ps});
      end
      step();
      check($sformatf("v%0d_idle", v), {62'd0, oBUSY, oDONE}, 64'd0);
    end

    // memory held busy: request must stay up with a stable address, then drop after one acceptance
    @(negedge clk);
    iMOD = 2'h1; iPS = 3'd0; iVADDR = 32'h0006_0000; iBASE = 32'h0100_0000;
    iMEM_LOCK = 1'b1; iREQ = 1'b1;
    step();
    iREQ = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("lock_req%0d", i), {63'd0, oMEM_REQ}, 64'd1);
      check($sformatf("lock_addr%0d", i), {32'd0, oMEM_ADDR}, 64'h0100_0008);
      step();
    end
    iMEM_LOCK = 1'b0;
    step();
    check("lock_req_drop", {63'd0, oMEM_REQ}, 64'd0);
    iMEM_VALID = 1'b1; iMEM_DATA = 64'h5555_0001_0000_0000;
    step();
    iMEM_VALID = 1'b0;
    check("lock_wr", {62'd0, oTLB_WR_REQ, oDONE}, 64'd3);
    check("lock_phys", oTLB_WR_PHYS_ADDR, 64'h5555_0001_0000_0000);
    step();
    check("lock_idle", {62'd0, oBUSY, oMEM_REQ}, 64'd0);

    // flush while waiting for the pair beat: drain it silently
    @(negedge clk);
    iREQ = 1'b1;
    step();
    iREQ = 1'b0;
    step();
    iREMOVE = 1'b1;
    step();
    iREMOVE = 1'b0;
    pulses = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("drain_busy%0d", i), {63'd0, oBUSY}, 64'd1);
      pulses = pulses | oDONE | oTLB_WR_REQ | oMEM_REQ;
      step();
    end
    iMEM_VALID = 1'b1; iMEM_DATA = 64'h0000_0001_0000_0001;
    step();
    iMEM_VALID = 1'b0;
    check("drain_exit", {63'd0, oBUSY}, 64'd0);
    pulses = pulses | oDONE | oTLB_WR_REQ;
    step();
    pulses = pulses | oDONE | oTLB_WR_REQ | oBUSY;
    check("drain_no_pulse", {63'd0, pulses}, 64'd0);

    // flush during a request phase aborts quietly
    @(negedge clk);
    iMOD = 2'h2; iVADDR = 32'h0040_3000; iBASE = 32'h0010_0000;
    iREQ = 1'b1;
    step();
    iREQ = 1'b0;
    iREMOVE = 1'b1;
    step();
    iREMOVE = 1'b0;
    check("req_flush", {61'd0, oBUSY, oDONE, oMEM_REQ}, 64'd0);

    // a request colliding with a flush in IDLE is dropped
    @(negedge clk);
    iREQ = 1'b1; iREMOVE = 1'b1;
    step();
    iREQ = 1'b0; iREMOVE = 1'b0;
    check("idle_flush_req", {63'd0, oBUSY}, 64'd0);

    // asynchronous reset in the middle of a walk
    @(negedge clk);
    iREQ = 1'b1;
    step();
    iREQ = 1'b0;
    check("mid_req", {63'd0, oMEM_REQ}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_ctrl", {60'd0, oBUSY, oMEM_REQ, oDONE, oTLB_WR_REQ}, 64'd0);
    check("mid_rst_addr", {32'd0, oMEM_ADDR}, 64'd0);
    check("mid_rst_tlb", {oTLB_WR_MOD, oTLB_WR_PS, oTLB_WR_ADDR, oFAULT}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
